bin_gray_serial_enc: RTL and testbench
======================================

Name: bin_gray_serial_enc

Overview:
Bit-serial binary-to-Gray encoder. It is the transmit-side counterpart to the team's serial Gray-to-binary decode path.
- A WIDTH-bit binary word is loaded on a start strobe.
- The word is shifted out MSB first as Gray-coded serial bits, one bit per clock, with a valid qualifier.
- The full Gray word is also presented in parallel with a one-cycle done pulse.
- The serial output feeds a serial Gray consumer directly; the parallel output serves local checking.

Parameters:
WIDTH, 5, word width in bits. Legal range is WIDTH >= 2.

Ports:
clk       input   1      rising-edge clock; the only clock.
rst_n     input   1      reset, asynchronous, active-low.
start     input   1      load request; sampled only while idle.
bin_in    input   WIDTH  binary word; captured on the edge where start is accepted.
busy      output  1      registered; high while a conversion is shifting.
ser_out   output  1      registered Gray serial bit, MSB first.
ser_valid output  1      registered; qualifies ser_out.
gray_out  output  WIDTH  registered parallel Gray word; holds its value until the next completion.
done      output  1      registered one-cycle pulse; gray_out is valid in the same cycle.

Behaviour:
Reset
- rst_n low asynchronously clears: state to IDLE, shift register, bit counter, prev-bit register, gray accumulator, and all outputs (busy, ser_out, ser_valid, gray_out, done all 0).
- Reset asserted mid-shift aborts the conversion with no done pulse.
- After rst_n rises, the first rising edge can accept start.

State machine
- Two states: IDLE and SHIFT.
- IDLE, start=1 at edge E0:
  - sreg <= bin_in, prev <= 0, count <= 0.
  - busy <= 1, state <= SHIFT.
  - done <= 0, ser_valid <= 0.
- IDLE, start=0: ser_valid <= 0, done <= 0. gray_out holds.
- SHIFT, edge Ek for k = 1..WIDTH:
  - b = sreg[WIDTH-1], g = b XOR prev.
  - ser_out <= g, ser_valid <= 1, prev <= b, sreg <= sreg << 1.
  - acc <= {acc[WIDTH-2:0], g}, count <= count + 1.
- At edge E_WIDTH (count == WIDTH-1):
  - state <= IDLE, busy <= 0, done <= 1.
  - gray_out <= {acc[WIDTH-2:0], g}.
  - ser_valid stays 1 for this final bit.

Latency and timing
- The serial bit for Gray index WIDTH-k is valid in the cycle after Ek.
- done and gray_out are valid in the cycle after E_WIDTH, coincident with the last serial bit.
- Throughput: a start at E_WIDTH+1 is accepted, giving one idle-valid cycle between words (WIDTH+1 cycles per word).

Boundary rules
- start while busy (SHIFT) is ignored; the in-flight word is unaffected.
- bin_in changes after the capture edge have no effect.
- start held high continuously: back-to-back words, each captured at the IDLE edge.

Arithmetic
- Gray encoding: gray = bin XOR (bin >> 1).
- Serial form: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] XOR b[i].
- prev = 0 at load is what makes the MSB pass through unchanged.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1.

Test Plan:
1. Reset then start with bin_in=5'b10110 → ser_out = 1,1,1,0,1 on 5 consecutive ser_valid cycles. done pulses once, with gray_out=5'b11101 in the final-bit cycle. busy is high for exactly 5 cycles.
2. Edge values: 5'b00000 → 00000. 5'b11111 → 10000 (serial 1,0,0,0,0). 5'b11010 → 10111. 5'b00001 → 00001.
3. Exhaustive sweep of 0..31 with start held high:
   - gray_out == b ^ (b>>1) for every word.
   - Each done is exactly WIDTH+1 cycles after the previous one.
   - ser_valid is low exactly one cycle between words.
4. Start with 5'b10110, then pulse start with 5'b01010 at cycle 2 while busy → ignored. Output is 11101, with a single done.
5. Start with 5'b11111, assert rst_n low after 3 serial bits → all outputs 0 immediately with no done. After release, start 5'b00011 → gray 00010.
6. WIDTH=8 instance: bin 8'hA5 → gray 8'hF7 (serial 1,1,1,1,0,1,1,1). done occurs 8 cycles after start acceptance.

Source files
------------

// File: rtl/bin_gray_serial_enc.sv
// Bit-serial binary-to-Gray encoder: loads a binary word on start, then emits its Gray code
// MSB first with a valid qualifier, plus the full parallel Gray word and a done pulse.
module bin_gray_serial_enc #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             busy_q, busy_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;
    logic             g;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        gray_d      = gray_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        busy_d      = busy_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        // prev starts at 0 so the MSB passes through unchanged
        g           = sreg_q[WIDTH-1] ^ prev_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = bin_in;
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                ser_out_d   = g;
                ser_valid_d = 1'b1;
                prev_d      = sreg_q[WIDTH-1];
                sreg_d      = {sreg_q[WIDTH-2:0], 1'b0};
                acc_d       = {acc_q[WIDTH-2:0], g};
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    gray_d  = {acc_q[WIDTH-2:0], g};
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            acc_q       <= '0;
            gray_q      <= '0;
            cnt_q       <= '0;
            prev_q      <= 1'b0;
            busy_q      <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            gray_q      <= gray_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            busy_q      <= busy_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign gray_out  = gray_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bin_gray_serial_enc.sv
// Self-checking bench for bin_gray_serial_enc: directed cases, a held-start sweep, reset abort,
// randomized words with ignored start noise, and an 8-bit instance.
module tb_bin_gray_serial_enc;

    localparam int unsigned W  = 5;
    localparam int unsigned W8 = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  bin_in = '0;
    logic          busy, ser_out, ser_valid, done;
    logic [W-1:0]  gray_out;

    logic          start8 = 1'b0;
    logic [W8-1:0] bin8 = '0;
    logic          busy8, ser_out8, ser_valid8, done8;
    logic [W8-1:0] gray8;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_gray_serial_enc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .busy(busy),
        .ser_out(ser_out), .ser_valid(ser_valid), .gray_out(gray_out), .done(done)
    );

    bin_gray_serial_enc #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8), .busy(busy8),
        .ser_out(ser_out8), .ser_valid(ser_valid8), .gray_out(gray8), .done(done8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: Gray code as plain arithmetic on the whole word.
    function automatic logic [31:0] to_gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // mode 0: quiet, 1: random start/bin_in noise while shifting, 2: one start pulse at cycle 2
    task automatic run5(input logic [W-1:0] b, input int mode, output logic [W-1:0] g);
        logic [31:0] gw;
        gw = to_gray(32'(b));
        g = gw[W-1:0];
        start = 1'b1;
        bin_in = b;
        @(negedge clk);
        check_val("load_busy", 32'(busy), 1);
        check_val("load_done", 32'(done), 0);
        check_val("load_valid", 32'(ser_valid), 0);
        start = 1'b0;
        if (mode == 1) bin_in = W'($urandom);
        if (mode == 2) begin
            start = 1'b1;
            bin_in = 5'b01010;
        end
        for (int k = 1; k <= int'(W); k++) begin
            @(negedge clk);
            check_val("ser_valid", 32'(ser_valid), 1);
            check_val("ser_out", 32'(ser_out), 32'(gw[W-k]));
            if (k == int'(W)) begin
                check_val("done_last", 32'(done), 1);
                check_val("gray_out", 32'(gray_out), gw);
                check_val("busy_last", 32'(busy), 0);
            end else begin
                check_val("done_early", 32'(done), 0);
                check_val("busy_mid", 32'(busy), 1);
            end
            start = 1'b0;
            if (mode == 1 && k < int'(W)) begin
                start = 1'($urandom_range(1, 0));
                bin_in = W'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic [W-1:0] hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle_valid", 32'(ser_valid), 0);
            check_val("idle_done", 32'(done), 0);
            check_val("idle_busy", 32'(busy), 0);
            check_val("idle_hold", 32'(gray_out), 32'(hold));
        end
    endtask

    initial begin
        logic [W-1:0]  g;
        logic [W-1:0]  edge_vals [4];
        logic [31:0]   gw;
        logic [31:0]   g8;
        int            prev_done;
        int            t0;

        edge_vals[0] = 5'b00000;
        edge_vals[1] = 5'b11111;
        edge_vals[2] = 5'b11010;
        edge_vals[3] = 5'b00001;

        #12;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_valid", 32'(ser_valid), 0);
        check_val("rst_ser", 32'(ser_out), 0);
        check_val("rst_gray", 32'(gray_out), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_gray8", 32'(gray8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run5(5'b10110, 0, g);
        idle_cycles(2, g);

        foreach (edge_vals[i]) begin
            run5(edge_vals[i], 0, g);
        end
        idle_cycles(1, g);

        // Second start while busy must not disturb the word or add a done pulse.
        run5(5'b10110, 2, g);
        idle_cycles(3, g);

        // Held start: back-to-back words, one idle-valid cycle between them.
        start = 1'b1;
        bin_in = '0;
        prev_done = -1;
        for (int w = 0; w < 32; w++) begin
            gw = to_gray(32'(w));
            @(negedge clk);
            check_val("sw_gap_valid", 32'(ser_valid), 0);
            check_val("sw_gap_busy", 32'(busy), 1);
            check_val("sw_gap_done", 32'(done), 0);
            bin_in = W'($urandom);
            for (int k = 1; k <= int'(W); k++) begin
                @(negedge clk);
                check_val("sw_valid", 32'(ser_valid), 1);
                check_val("sw_ser", 32'(ser_out), 32'(gw[W-k]));
                check_val("sw_done", 32'(done), (k == int'(W)) ? 1 : 0);
                if (k == int'(W)) begin
                    check_val("sw_gray", 32'(gray_out), gw);
                    if (prev_done >= 0) check_val("sw_period", 32'(cyc - prev_done), W + 1);
                    prev_done = cyc;
                    bin_in = W'(w + 1);
                    if (w == 31) start = 1'b0;
                end
            end
        end
        idle_cycles(1, 5'b10000);

        // Reset mid-shift aborts without a done pulse.
        start = 1'b1;
        bin_in = 5'b11111;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_valid", 32'(ser_valid), 0);
        check_val("abort_ser", 32'(ser_out), 0);
        check_val("abort_gray", 32'(gray_out), 0);
        check_val("abort_done", 32'(done), 0);
        @(negedge clk);
        check_val("abort_done2", 32'(done), 0);
        rst_n = 1'b1;
        run5(5'b00011, 0, g);
        check_val("post_rst_gray", 32'(g), 32'h02);

        for (int n = 0; n < 30; n++) begin
            run5(W'($urandom), 1, g);
            idle_cycles(int'($urandom_range(3, 0)), g);
        end

        start8 = 1'b1;
        bin8 = 8'hA5;
        g8 = to_gray(32'h0000_00A5);
        @(negedge clk);
        start8 = 1'b0;
        bin8 = 8'h00;
        t0 = cyc;
        check_val("w8_busy", 32'(busy8), 1);
        for (int k = 1; k <= int'(W8); k++) begin
            @(negedge clk);
            check_val("w8_valid", 32'(ser_valid8), 1);
            check_val("w8_ser", 32'(ser_out8), 32'(g8[W8-k]));
            check_val("w8_done", 32'(done8), (k == int'(W8)) ? 1 : 0);
            if (k == int'(W8)) begin
                check_val("w8_gray", 32'(gray8), g8);
                check_val("w8_latency", 32'(cyc - t0), W8);
            end
        end
        @(negedge clk);
        check_val("w8_done_pulse", 32'(done8), 0);
        check_val("w8_gray_hold", 32'(gray8), 32'hF7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
